// File: rtl/sparc_mem_pkg.sv
// Shared encodings for the SPARC memory controller: access sizes, FSM states,
// wait-state counter width and small decode helpers.
package sparc_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_ACCESS = 3'd2,
        ST_DONE   = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    // Type 11 is handled exactly like a word everywhere.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return a_lo[0];
            default: return a_lo != 2'b00;
        endcase
    endfunction

    // Lane 0 holds the byte at the request address (most significant byte).
    function automatic logic [3:0] lane_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 4'b0001;
            SZ_HALF: return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/sparc_mem_if.sv
// Request/response bus between the MPU control unit (master) and the memory
// controller (slave). acc_type carries the 2-bit access size.
interface sparc_mem_if;
    logic        mov;
    logic        r_w;
    logic [1:0]  acc_type;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        MOC;
    logic        busy;
    logic        mem_err;

    modport master (
        output mov, r_w, acc_type, sgn, addr, data_in,
        input  data_out, MOC, busy, mem_err
    );

    modport slave (
        input  mov, r_w, acc_type, sgn, addr, data_in,
        output data_out, MOC, busy, mem_err
    );
endinterface

// File: rtl/sparc_byte_ram.sv
// Byte-addressed RAM with four lanes covering A..A+3 (wrapping modulo size);
// asynchronous read, per-lane synchronous write. Lane 0 maps to bits [31:24].
module sparc_byte_ram
    import sparc_mem_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [3:0]        lane_we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] lane_addr [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_addr[gi]       = base_addr + ADDR_W'(gi);
            assign rdata[31-8*gi -: 8] = mem[lane_addr[gi]];
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (lane_we[i]) begin
                mem[lane_addr[i]] <= wdata[31-8*i -: 8];
            end
        end
    end

endmodule

// File: rtl/sparc_mem_ctrl.sv
// SPARC MPU memory controller: wait states, big-endian byte/half/word access,
// sign-extended loads, MOC handshake. SPARC_MEM_ALIGN_CHK_EN enables mem_err.
module sparc_mem_ctrl
    import sparc_mem_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic Clk,
    input  logic Clr,
    sparc_mem_if.slave bus
);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  wait_cnt_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [1:0]        size_reg;
    logic              rw_reg;
    logic              sgn_reg;
    logic [31:0]       din_reg;
    logic [31:0]       dout_reg;
    logic              moc_reg;
    logic              busy_reg;

    logic              misaligned;
    logic [3:0]        lane_we;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic [31:0]       load_data;

    // Address bits above the RAM size are deliberately ignored (wrap-around).
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.addr[31:ADDR_W];

`ifdef SPARC_MEM_ALIGN_CHK_EN
    logic err_reg;
    assign misaligned  = is_misaligned(size_reg, addr_reg[1:0]);
    assign bus.mem_err = err_reg;

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= (state_reg == ST_ACCESS) && misaligned;
        end
    end
`else
    assign misaligned  = 1'b0;
    assign bus.mem_err = 1'b0;
`endif

    sparc_byte_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk       (Clk),
        .base_addr (addr_reg),
        .lane_we   (lane_we),
        .wdata     (ram_wdata),
        .rdata     (ram_rdata)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (bus.mov) state_next = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
            ST_WAIT:   if (wait_cnt_reg == '0) state_next = ST_ACCESS;
            ST_ACCESS: state_next = ST_DONE;
            ST_DONE:   state_next = bus.mov ? ST_HOLD : ST_IDLE;
            ST_HOLD:   if (!bus.mov) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Store data is left-justified so lane 0 always receives the first byte.
    always_comb begin
        case (size_reg)
            SZ_BYTE: ram_wdata = {din_reg[7:0], 24'h0};
            SZ_HALF: ram_wdata = {din_reg[15:0], 16'h0};
            default: ram_wdata = din_reg;
        endcase
        lane_we = (state_reg == ST_ACCESS && !rw_reg && !misaligned) ? lane_mask(size_reg) : 4'b0000;
        case (size_reg)
            SZ_BYTE: load_data = {{24{sgn_reg & ram_rdata[31]}}, ram_rdata[31:24]};
            SZ_HALF: load_data = {{16{sgn_reg & ram_rdata[31]}}, ram_rdata[31:16]};
            default: load_data = ram_rdata;
        endcase
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= '0;
            addr_reg     <= '0;
            size_reg     <= SZ_BYTE;
            rw_reg       <= 1'b0;
            sgn_reg      <= 1'b0;
            din_reg      <= '0;
            dout_reg     <= '0;
            moc_reg      <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next != ST_IDLE);
            moc_reg   <= (state_reg == ST_ACCESS);
            if (state_reg == ST_IDLE && bus.mov) begin
                addr_reg     <= bus.addr[ADDR_W-1:0];
                size_reg     <= bus.acc_type;
                rw_reg       <= bus.r_w;
                sgn_reg      <= bus.sgn;
                din_reg      <= bus.data_in;
                wait_cnt_reg <= WAIT_LOAD;
            end else if (state_reg == ST_WAIT && wait_cnt_reg != '0) begin
                wait_cnt_reg <= wait_cnt_reg - CNT_W'(1);
            end
            if (state_reg == ST_ACCESS && rw_reg && !misaligned) begin
                dout_reg <= load_data;
            end
        end
    end

    assign bus.data_out = dout_reg;
    assign bus.MOC      = moc_reg;
    assign bus.busy     = busy_reg;

endmodule

// File: doc/sparc_mem_ctrl.md
# sparc_mem_ctrl

Parametrised memory controller for the SPARC MPU: accepts load/store requests from the control unit (`mov`, `r_w`, `type`) with address and store data from the datapath, and performs byte/halfword/word accesses on an internal big-endian byte-addressed RAM. It adds configurable wait states, sign-extended loads and misaligned-access detection. It completes each request through the `MOC` (memory operation complete) handshake the control unit already polls. It replaces the fixed-latency, word-only RAM model in the next MPU generation.

## Interface
- `ADDR_W`, 9, address bits decoded; the RAM holds 2^ADDR_W bytes.
- `WAIT_CYCLES`, 2, wait states inserted before each access completes; legal range 0..15.
- `Clk` in 1: single clock, rising edge.
- `Clr` in 1: asynchronous, active-low reset.
- `mov` in 1: request strobe, level-held by the control unit until `MOC` is seen.
- `r_w` in 1: 1 = read (load), 0 = write (store).
- `type` in 2: access size; 00 = byte, 01 = halfword, 10 = word, 11 = treated as word.
- `sgn` in 1: sign-extend byte/halfword loads when 1, zero-extend when 0.
- `addr` in 32: byte address; bits above ADDR_W-1 are ignored, so the address wraps modulo 2^ADDR_W.
- `data_in` in 32: store data, right-justified.
- `data_out` out 32: load result, registered.
- `MOC` out 1: single-cycle completion pulse, registered.
- `busy` out 1: high from request acceptance until the FSM returns to IDLE.
- `mem_err` out 1: misaligned-access flag, valid only while `MOC` = 1.

## Operation
- FSM states: IDLE, WAIT, ACCESS, DONE, HOLD.
- **IDLE**: a rising edge with `mov` = 1 latches `addr`, `type`, `r_w`, `sgn` and `data_in`. The FSM then goes to WAIT, or straight to ACCESS when WAIT_CYCLES = 0. Inputs after the latch are don't-care.
- **WAIT**: a 4-bit counter loads WAIT_CYCLES-1 and decrements each cycle. At 0 the FSM goes to ACCESS.
- **ACCESS**: lasts one cycle and performs the RAM read or write. The following edge registers `data_out` for reads and moves the FSM to DONE.
- **DONE**: `MOC` = 1 for exactly one cycle. The FSM goes to IDLE if `mov` = 0, otherwise to HOLD.
- **HOLD**: stays until `mov` = 0, then goes to IDLE. A still-high `mov` is never taken as a new request.
- **Byte order**: big-endian. A halfword is {M[A], M[A+1]}; a word is {M[A], M[A+1], M[A+2], M[A+3]}.
- **Reads**: a byte read returns M[A] in `data_out[7:0]`; a halfword read returns its 16 bits in `data_out[15:0]`. Upper bits are filled with the MSB of the datum when `sgn` = 1, else with zeros. A word read ignores `sgn`.
- **Writes**: store `data_in[7:0]`, `[15:0]` or `[31:0]` to the addressed bytes. `data_out` is unchanged by a write.
- **Word/halfword wrap**: bytes beyond the top address wrap to address 0. This case only arises when alignment checking is compiled out.

## Timing
- Reset (`Clr` = 0, asynchronous): FSM goes to IDLE and the counter clears. `data_out` = 0, `MOC` = 0, `busy` = 0, `mem_err` = 0.
- RAM contents are not cleared by reset. A reset during WAIT or ACCESS aborts the request: no write occurs, even if `Clr` falls in the ACCESS cycle.
- Latency: if `mov` is sampled at edge N, `MOC` is high during cycle N+WAIT_CYCLES+2. `data_out` is valid from that same cycle and holds until the next read completes.
- `busy` rises in the cycle after edge N and falls on entry to IDLE.
- Minimum request spacing: `mov` must be low for at least one edge between requests.
- A write is committed at the edge that ends the ACCESS cycle. A read in a later request returns the new value.

## Configuration
- Macro `SPARC_MEM_ALIGN_CHK_EN`.
- **Defined**: a halfword at an odd address, or a word/type-11 access with addr[1:0] ≠ 0, is misaligned. Such a request still passes through WAIT and ACCESS, but performs no RAM access. In DONE, `MOC` = 1 and `mem_err` = 1, and `data_out` is unchanged.
- **Undefined**: no check is made; accesses use the unaligned address as given (byte-granular, with wrap). `mem_err` is tied to 0.

## Structure
- Package `sparc_mem_pkg` holds:
  - the `type` encodings (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`);
  - the FSM state enum;
  - the WAIT_CYCLES counter width (4).
- Sub-module `sparc_byte_ram`: 2^ADDR_W × 8 array with four byte lanes.
  - Each lane has its own address (A..A+3 modulo size) and write enable.
  - Asynchronous read.
  - The controller instantiates it once.

## Test plan
- Reset, then word write 0xDEADBEEF at addr 0x10, then word read at 0x10, with WAIT_CYCLES=2 → `data_out` = 0xDEADBEEF; `MOC` pulses exactly 4 cycles after the sampled `mov` edge.
- After that write: byte read at 0x13 with `sgn`=1 → 0xFFFFFFEF; with `sgn`=0 → 0x000000EF. Halfword read at 0x10 with `sgn`=1 → 0xFFFFDEAD.
- Byte write 0x5A at 0x11, then word read at 0x10 → 0xDE5ABEEF.
- `SPARC_MEM_ALIGN_CHK_EN` defined: word write at 0x12 → `MOC`=1 with `mem_err`=1; a following word read at 0x10 is still 0xDE5ABEEF.
- `mov` held high for 10 cycles after `MOC` → exactly one `MOC` pulse. WAIT_CYCLES=0 → `MOC` 2 cycles after the sampled `mov` edge.
- Pull `Clr` low during WAIT of a word write of 0x12345678 to 0x20 → all outputs 0 immediately; a later read of 0x20 returns the old contents.
